// File: rtl/operand_issue_stage_pkg.sv
// Shared widths, opcode constants, the ID/EX payload and the operand bypass helper
// for the decode/operand issue stage.
package operand_issue_stage_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned OPW  = 3;
    localparam int unsigned FW   = 3;
    localparam int unsigned IMMW = 4;

    localparam logic [FW-1:0]  RST_PC_FLAG = 3'b000;
    localparam logic [3:0]     OPC_LW      = 4'd8;
    localparam logic [3:0]     OPC_SW      = 4'd9;
    localparam logic [OPW-1:0] ALU_ADD     = 3'd0;

    typedef struct packed {
        logic            valid;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [OPW-1:0]  op;
        logic [IMMW-1:0] imm;
        logic [AW-1:0]   rd;
        logic            wen;
        logic            is_load;
        logic            upd_flag;
    } idex_t;

    // Bypass priority: r0, then the ALU result in EX, then the writeback port, then the regfile.
    function automatic logic [DW-1:0] fwd_operand(
        input logic [AW-1:0] src,
        input logic [DW-1:0] rf_val,
        input logic          ex_fwd,
        input logic [AW-1:0] ex_rd,
        input logic [DW-1:0] alu_out,
        input logic          wb_en,
        input logic [AW-1:0] wb_addr,
        input logic [DW-1:0] wb_data
    );
        if (src == '0)
            return '0;
        else if (ex_fwd && (ex_rd == src))
            return alu_out;
        else if (wb_en && (wb_addr == src))
            return wb_data;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/operand_issue_stage_regfile.sv
// 16x16 register file: three asynchronous read ports, one synchronous write port.
// r0 is never written so it always reads zero.
module operand_issue_stage_regfile
    import operand_issue_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_c,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic [DW-1:0] rdata_c,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '{default: '0};
        else if (we && (waddr != '0))
            mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode/operand stage feeding the ALU: decode, operand bypass, load-use bubble,
// ID/EX pipeline register and the flag register.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [15:0]     in_instr,
    output logic            in_ready,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic [DW-1:0]   alu_out,
    input  logic [FW-1:0]   alu_flag,
    input  logic            hold,
    input  logic            flush,
    output logic [DW-1:0]   A,
    output logic [DW-1:0]   B,
    output logic [OPW-1:0]  op,
    output logic [IMMW-1:0] imm,
    output logic [FW-1:0]   lastFlag,
    output logic            ex_valid,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_wen,
    output logic            ex_is_load
);

    logic [3:0]    opc;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rt_a;
    logic [DW-1:0] rf_rs;
    logic [DW-1:0] rf_rt;
    logic [DW-1:0] rf_rd;
    logic [DW-1:0] opnd_rs;
    logic [DW-1:0] opnd_rt;
    logic [DW-1:0] opnd_rd;
    logic          ex_fwd;
    logic          ld_pend;
    logic          load_use;
    logic          need_rs;
    logic          need_rt;
    logic          need_rd;
    idex_t         dec;
    idex_t         idex_q;
    idex_t         idex_d;
    logic [FW-1:0] flag_q;
    logic [FW-1:0] flag_d;

    assign opc  = in_instr[15:12];
    assign rd_a = in_instr[11:8];
    assign rs_a = in_instr[7:4];
    assign rt_a = in_instr[3:0];

    operand_issue_stage_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs_a),
        .raddr_b (rt_a),
        .raddr_c (rd_a),
        .rdata_a (rf_rs),
        .rdata_b (rf_rt),
        .rdata_c (rf_rd),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // A load in EX has no result on alu_out yet, so it is excluded from the EX bypass.
    assign ex_fwd  = idex_q.valid & idex_q.wen & ~idex_q.is_load;
    assign opnd_rs = fwd_operand(rs_a, rf_rs, ex_fwd, idex_q.rd, alu_out, wb_en, wb_addr, wb_data);
    assign opnd_rt = fwd_operand(rt_a, rf_rt, ex_fwd, idex_q.rd, alu_out, wb_en, wb_addr, wb_data);
    assign opnd_rd = fwd_operand(rd_a, rf_rd, ex_fwd, idex_q.rd, alu_out, wb_en, wb_addr, wb_data);

    // Instruction decode into the ID/EX payload plus the set of sources actually consumed.
    always_comb begin
        dec      = '0;
        need_rs  = 1'b0;
        need_rt  = 1'b0;
        need_rd  = 1'b0;
        dec.valid = 1'b1;
        dec.imm   = in_instr[3:0];
        dec.rd    = rd_a;
        if (!opc[3]) begin
            dec.op       = opc[2:0];
            dec.a        = opnd_rs;
            dec.b        = opnd_rt;
            dec.wen      = 1'b1;
            dec.upd_flag = 1'b1;
            need_rs      = 1'b1;
            need_rt      = 1'b1;
        end else if (opc == OPC_LW) begin
            dec.op       = ALU_ADD;
            dec.a        = opnd_rs;
            dec.wen      = 1'b1;
            dec.is_load  = 1'b1;
            dec.upd_flag = 1'b1;
            need_rs      = 1'b1;
        end else if (opc == OPC_SW) begin
            dec.op       = ALU_ADD;
            dec.a        = opnd_rs;
            dec.b        = opnd_rd;
            dec.upd_flag = 1'b1;
            need_rs      = 1'b1;
            need_rd      = 1'b1;
        end
    end

    assign ld_pend  = idex_q.valid & idex_q.is_load & (idex_q.rd != '0);
    assign load_use = in_valid & ld_pend &
                      ((need_rs & (idex_q.rd == rs_a)) |
                       (need_rt & (idex_q.rd == rt_a)) |
                       (need_rd & (idex_q.rd == rd_a)));
    assign in_ready = ~rst & ~hold & ~load_use;

    // Flush beats hold; a non-accepted cycle without hold inserts a bubble.
    always_comb begin
        idex_d = idex_q;
        flag_d = flag_q;
        if (flush) begin
            idex_d.valid    = 1'b0;
            idex_d.wen      = 1'b0;
            idex_d.is_load  = 1'b0;
            idex_d.upd_flag = 1'b0;
        end else if (!hold) begin
            if (idex_q.valid && idex_q.upd_flag)
                flag_d = alu_flag;
            if (in_valid && in_ready) begin
                idex_d = dec;
            end else begin
                idex_d.valid    = 1'b0;
                idex_d.wen      = 1'b0;
                idex_d.is_load  = 1'b0;
                idex_d.upd_flag = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
            flag_q <= RST_PC_FLAG;
        end else begin
            idex_q <= idex_d;
            flag_q <= flag_d;
        end
    end

    assign A          = idex_q.a;
    assign B          = idex_q.b;
    assign op         = idex_q.op;
    assign imm        = idex_q.imm;
    assign ex_rd      = idex_q.rd;
    assign ex_valid   = idex_q.valid;
    assign ex_wen     = idex_q.wen;
    assign ex_is_load = idex_q.is_load;
    assign lastFlag   = flag_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: directed vector table, hand-written reset sequence,
// then randomized traffic against an instruction-level reference model.
module tb_operand_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] alu_out;
    logic [2:0]  alu_flag;
    logic        hold;
    logic        flush;
    logic [15:0] dut_a;
    logic [15:0] dut_b;
    logic [2:0]  op;
    logic [3:0]  imm;
    logic [2:0]  last_flag;
    logic        ex_valid;
    logic [3:0]  ex_rd;
    logic        ex_wen;
    logic        ex_is_load;

    int n_cmp = 0;
    int n_bad = 0;

    operand_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .alu_out    (alu_out),
        .alu_flag   (alu_flag),
        .hold       (hold),
        .flush      (flush),
        .A          (dut_a),
        .B          (dut_b),
        .op         (op),
        .imm        (imm),
        .lastFlag   (last_flag),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, A, B, op, imm, rd, wen, load, flag}
    function automatic logic [48:0] dut_outs();
        return {ex_valid, dut_a, dut_b, op, imm, ex_rd, ex_wen, ex_is_load, last_flag};
    endfunction

    task automatic check(input string name, input logic [48:0] got, input logic [48:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_instr = 16'h0; wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
        alu_out = 16'h0; alu_flag = 3'b000; hold = 1'b0; flush = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        iv;
        logic [15:0] instr;
        logic        wbe;
        logic [3:0]  wba;
        logic [15:0] wbd;
        logic [15:0] aluo;
        logic [2:0]  aluf;
        logic        hld;
        logic        fls;
        logic        e_rdy;
        logic [48:0] e_out;
    } vec_t;

    function automatic vec_t row(input string n, input logic iv, input logic [15:0] ins,
                                 input logic wbe, input logic [3:0] wba, input logic [15:0] wbd,
                                 input logic [15:0] aluo, input logic [2:0] aluf,
                                 input logic hld, input logic fls, input logic rdy,
                                 input logic v, input logic [15:0] ea, input logic [15:0] eb,
                                 input logic [2:0] eop, input logic [3:0] eimm, input logic [3:0] erd,
                                 input logic ewen, input logic eld, input logic [2:0] efl);
        vec_t r;
        r.name = n; r.iv = iv; r.instr = ins; r.wbe = wbe; r.wba = wba; r.wbd = wbd;
        r.aluo = aluo; r.aluf = aluf; r.hld = hld; r.fls = fls; r.e_rdy = rdy;
        r.e_out = {v, ea, eb, eop, eimm, erd, ewen, eld, efl};
        return r;
    endfunction

    // Reference model: architectural registers plus the instruction sitting in EX.
    typedef struct {
        logic        valid;
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  imm;
        logic [3:0]  rd;
    } mex_t;

    logic [15:0] m_rf [16];
    mex_t        m_ex;
    logic [2:0]  m_flag;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        m_ex = '{valid: 1'b0, opc: 4'h0, a: 16'h0, b: 16'h0, imm: 4'h0, rd: 4'h0};
        m_flag = 3'b000;
    endtask

    function automatic logic [15:0] m_opnd(input logic [3:0] src);
        if (src == 4'd0) return 16'h0;
        if (m_ex.valid && m_ex.opc <= 4'd7 && m_ex.rd == src) return alu_out;
        if (wb_en && wb_addr == src) return wb_data;
        return m_rf[src];
    endfunction

    function automatic logic [48:0] model_outs();
        logic [3:0] o4;
        logic [2:0] mop;
        o4  = m_ex.opc;
        mop = (o4 <= 4'd7) ? o4[2:0] : 3'd0;
        return {m_ex.valid, m_ex.a, m_ex.b, mop, m_ex.imm, m_ex.rd,
                m_ex.valid && (m_ex.opc <= 4'd8), m_ex.valid && (m_ex.opc == 4'd8), m_flag};
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", dut_outs(), 49'h0);
        check("reset_ready", {48'h0, in_ready}, 49'h0);
        rst = 1'b0;

        //              name            iv instr    wbe wba   wbd       aluo      aluf   h  f  rdy v  A         B         op    imm   rd    wen ld fl
        vecs.push_back(row("wb_r3",        0, 16'h0000, 1, 4'h3, 16'h1234, 16'h0000, 3'd0, 0, 0, 1, 0, 16'h0000, 16'h0000, 3'd0, 4'h0, 4'h0, 0, 0, 3'd0));
        vecs.push_back(row("add_r4_rf",    1, 16'h0433, 0, 4'h0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h1234, 16'h1234, 3'd0, 4'h3, 4'h4, 1, 0, 3'd0));
        vecs.push_back(row("add_r5",       1, 16'h0512, 0, 4'h0, 16'h0000, 16'h1111, 3'd0, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h2, 4'h5, 1, 0, 3'd0));
        vecs.push_back(row("sub_r6_exfwd", 1, 16'h1655, 0, 4'h0, 16'h0000, 16'h00FF, 3'd0, 0, 0, 1, 1, 16'h00FF, 16'h00FF, 3'd1, 4'h5, 4'h6, 1, 0, 3'd0));
        vecs.push_back(row("lw_r7",        1, 16'h8724, 0, 4'h0, 16'h0000, 16'h0AAA, 3'd5, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h4, 4'h7, 1, 1, 3'd5));
        vecs.push_back(row("and_stall",    1, 16'h2871, 0, 4'h0, 16'h0000, 16'h0123, 3'd2, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, 4'h4, 4'h7, 0, 0, 3'd2));
        vecs.push_back(row("and_wbfwd",    1, 16'h2871, 1, 4'h7, 16'hBEEF, 16'h5555, 3'd7, 0, 0, 1, 1, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 1, 0, 3'd2));
        vecs.push_back(row("hold1",        1, 16'h0911, 0, 4'h0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 1, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 1, 0, 3'd2));
        vecs.push_back(row("hold2",        1, 16'h0911, 0, 4'h0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 1, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 1, 0, 3'd2));
        vecs.push_back(row("hold3_wb_r9",  1, 16'h0911, 1, 4'h9, 16'h0999, 16'h0000, 3'd1, 1, 0, 0, 1, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 1, 0, 3'd2));
        vecs.push_back(row("flush_hold",   1, 16'h0911, 0, 4'h0, 16'h0000, 16'h0000, 3'd1, 1, 1, 0, 0, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 0, 0, 3'd2));
        vecs.push_back(row("wr_r0",        0, 16'h0000, 1, 4'h0, 16'hFFFF, 16'h0000, 3'd0, 0, 0, 1, 0, 16'hBEEF, 16'h0000, 3'd2, 4'h1, 4'h8, 0, 0, 3'd2));
        vecs.push_back(row("rd_r0",        1, 16'h0A09, 1, 4'h0, 16'hFFFF, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h0000, 16'h0999, 3'd0, 4'h9, 4'hA, 1, 0, 3'd2));
        vecs.push_back(row("or_flag",      1, 16'h3BAA, 0, 4'h0, 16'h0000, 16'h7777, 3'd5, 0, 0, 1, 1, 16'h7777, 16'h7777, 3'd3, 4'hA, 4'hB, 1, 0, 3'd5));
        vecs.push_back(row("sw_rd_fwd",    1, 16'h9B92, 0, 4'h0, 16'h0000, 16'h4242, 3'd0, 0, 0, 1, 1, 16'h0999, 16'h4242, 3'd0, 4'h2, 4'hB, 0, 0, 3'd0));
        vecs.push_back(row("opc_f",        1, 16'hF123, 0, 4'h0, 16'h0000, 16'h0000, 3'd6, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h3, 4'h1, 0, 0, 3'd6));
        vecs.push_back(row("after_opc_f",  0, 16'h0000, 0, 4'h0, 16'h0000, 16'h0000, 3'd3, 0, 0, 1, 0, 16'h0000, 16'h0000, 3'd0, 4'h3, 4'h1, 0, 0, 3'd6));
        vecs.push_back(row("flush_only",   1, 16'h0C11, 0, 4'h0, 16'h0000, 16'h0000, 3'd7, 0, 1, 1, 0, 16'h0000, 16'h0000, 3'd0, 4'h3, 4'h1, 0, 0, 3'd6));
        vecs.push_back(row("lw_r0",        1, 16'h8010, 0, 4'h0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h0, 4'h0, 1, 1, 3'd6));
        vecs.push_back(row("use_r0",       1, 16'h0C00, 0, 4'h0, 16'h0000, 16'h0000, 3'd1, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h0, 4'hC, 1, 0, 3'd1));
        vecs.push_back(row("lw_r13",       1, 16'h8D20, 0, 4'h0, 16'h0000, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h0000, 16'h0000, 3'd0, 4'h0, 4'hD, 1, 1, 3'd0));
        vecs.push_back(row("rt_stall",     1, 16'h0E1D, 0, 4'h0, 16'h0000, 16'h0000, 3'd4, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0, 4'h0, 4'hD, 0, 0, 3'd4));
        vecs.push_back(row("rt_wbfwd",     1, 16'h0E1D, 1, 4'hD, 16'hCAFE, 16'h0000, 3'd0, 0, 0, 1, 1, 16'h0000, 16'hCAFE, 3'd0, 4'hD, 4'hE, 1, 0, 3'd4));

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv;  in_instr = vecs[i].instr;
            wb_en = vecs[i].wbe;    wb_addr = vecs[i].wba;  wb_data = vecs[i].wbd;
            alu_out = vecs[i].aluo; alu_flag = vecs[i].aluf;
            hold = vecs[i].hld;     flush = vecs[i].fls;
            @(negedge clk);
            check({vecs[i].name, "_ready"}, {48'h0, in_ready}, {48'h0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check(vecs[i].name, dut_outs(), vecs[i].e_out);
        end

        // Asynchronous reset in the middle of a cycle with a live instruction in EX.
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outs", dut_outs(), 49'h0);
        check("midrst_ready", {48'h0, in_ready}, 49'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_instr = 16'h0137;
        @(posedge clk);
        #1;
        check("post_rst_rf_zero", dut_outs(),
              {1'b1, 16'h0000, 16'h0000, 3'd0, 4'h7, 4'h1, 1'b1, 1'b0, 3'd0});

        // Randomized traffic against the reference model.
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  mopc, mrd, mrs, mrt;
            logic [3:0]  srcs[$];
            logic        stall, exp_rdy;
            mex_t        nx;
            logic [2:0]  nflag;

            in_valid = ($urandom_range(0, 3) != 0);
            mopc     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            in_instr = {mopc, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            wb_en    = 1'($urandom_range(0, 1));
            wb_addr  = 4'($urandom_range(0, 4));
            wb_data  = 16'($urandom);
            alu_out  = 16'($urandom);
            alu_flag = 3'($urandom);
            hold     = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 199) == 0);

            @(negedge clk);
            mrd = in_instr[11:8];
            mrs = in_instr[7:4];
            mrt = in_instr[3:0];
            srcs.delete();
            if (mopc <= 4'd7) begin
                srcs.push_back(mrs); srcs.push_back(mrt);
            end else if (mopc == 4'd8) begin
                srcs.push_back(mrs);
            end else if (mopc == 4'd9) begin
                srcs.push_back(mrs); srcs.push_back(mrd);
            end
            stall = 1'b0;
            foreach (srcs[k])
                if (in_valid && m_ex.valid && m_ex.opc == 4'd8 && srcs[k] != 4'd0 && srcs[k] == m_ex.rd)
                    stall = 1'b1;
            exp_rdy = !rst && !hold && !stall;
            check("rand_ready", {48'h0, in_ready}, {48'h0, exp_rdy});

            nx = m_ex;
            nflag = m_flag;
            if (flush) begin
                nx.valid = 1'b0;
            end else if (!hold) begin
                if (m_ex.valid && m_ex.opc <= 4'd9) nflag = alu_flag;
                if (in_valid && exp_rdy) begin
                    nx.valid = 1'b1;
                    nx.opc   = mopc;
                    nx.rd    = mrd;
                    nx.imm   = mrt;
                    nx.a     = (mopc <= 4'd9) ? m_opnd(mrs) : 16'h0;
                    nx.b     = (mopc <= 4'd7) ? m_opnd(mrt) : (mopc == 4'd9) ? m_opnd(mrd) : 16'h0;
                end else begin
                    nx.valid = 1'b0;
                end
            end

            @(posedge clk);
            #1;
            if (rst) begin
                model_reset();
            end else begin
                if (wb_en && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
                m_ex   = nx;
                m_flag = nflag;
            end
            check("rand_outs", dut_outs(), model_outs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
